// File: rtl/dsp_pipe_stage_if.sv
// Upstream/downstream valid-ready stream bundle for dsp_pipe_stage.
// The slave view belongs to the pipeline; the master view belongs to its environment.
interface dsp_pipe_stage_if #(
    parameter int unsigned WIDTH = 18
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/dsp_pipe_stage.sv
// Valid/ready register chain of DEPTH stages with bubble collapse, clock enable,
// synchronous flush and an occupancy count; DEPTH=0 degenerates to wires.
module dsp_pipe_stage #(
    parameter int unsigned      WIDTH  = 18,
    parameter int unsigned      DEPTH  = 1,
    parameter logic [WIDTH-1:0] RSTVAL = '0,
    localparam int unsigned     CNT_W  = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    dsp_pipe_stage_if.slave  bus,
    output logic [CNT_W-1:0] count
);

    if (WIDTH == 0 || WIDTH > 48) begin : g_bad_width
        $error("dsp_pipe_stage: WIDTH=%0d outside legal range 1..48", WIDTH);
    end

    if (DEPTH > 4) begin : g_bad_depth
        $error("dsp_pipe_stage: DEPTH=%0d outside legal range 0..4", DEPTH);
    end

    if (DEPTH == 0) begin : g_comb
        logic unused_ok;

        assign bus.out_data  = bus.in_data;
        assign bus.out_valid = ce & bus.in_valid;
        assign bus.in_ready  = ce & bus.out_ready;
        assign count         = '0;
        assign unused_ok     = &{1'b0, clk, rst, clr};
    end else begin : g_pipe
        logic [DEPTH:1]   v_q;
        logic [WIDTH-1:0] d_q [1:DEPTH];
        logic [DEPTH:1]   rdy;

        // A stage can take new data if it is empty or everything below it will move.
        always_comb begin : ready_chain
            logic r;
            r   = bus.out_ready;
            rdy = '0;
            for (int k = int'(DEPTH); k >= 1; k--) begin
                r      = ~v_q[k] | r;
                rdy[k] = r;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                for (int k = 1; k <= int'(DEPTH); k++) d_q[k] <= RSTVAL;
            end else if (clr) begin
                v_q <= '0;
                for (int k = 1; k <= int'(DEPTH); k++) d_q[k] <= RSTVAL;
            end else if (ce) begin
                if (rdy[1]) begin
                    v_q[1] <= bus.in_valid;
                    if (bus.in_valid) d_q[1] <= bus.in_data;
                end
                // Data registers only load on valid so a bubble leaves the old word in place.
                for (int k = 2; k <= int'(DEPTH); k++) begin
                    if (rdy[k]) begin
                        v_q[k] <= v_q[k-1];
                        if (v_q[k-1]) d_q[k] <= d_q[k-1];
                    end
                end
            end
        end

        assign bus.in_ready  = ce & rdy[1];
        assign bus.out_valid = ce & v_q[DEPTH];
        assign bus.out_data  = d_q[DEPTH];

        always_comb begin
            count = '0;
            for (int k = 1; k <= int'(DEPTH); k++) count = count + CNT_W'(v_q[k]);
        end
    end

endmodule
